// File: rtl/pipe_event_monitor.sv
// Cycle/event bookkeeping for a pipelined CPU: saturating counters, a programmable
// cycle limit that raises done_o, and a first-word-fall-through PC trace FIFO.
module pipe_event_monitor #(
    parameter int NUM_EVT     = 2,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic [CNT_W-1:0]               limit_i,
    input  logic [NUM_EVT-1:0]             evt_i,
    input  logic [PC_W-1:0]                pc_i,
    input  logic                           pc_valid_i,
    input  logic                           trace_rd_i,
    output logic [CNT_W-1:0]               cycle_cnt_o,
    output logic [NUM_EVT*CNT_W-1:0]       evt_cnt_o,
    output logic [PC_W-1:0]                trace_data_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count_o,
    output logic                           trace_empty_o,
    output logic                           trace_full_o,
    output logic                           trace_ovf_o,
    output logic                           done_o
);

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [AW:0]      DEPTH_C  = (AW+1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_t                 state_r, state_nxt_s;
    logic                   count_en_s;
    logic [CNT_W-1:0]       cycle_cnt_r;
    logic [CNT_W-1:0]       evt_cnt_r [NUM_EVT];
    logic                   done_r;

    logic [PC_W-1:0]        mem_r [TRACE_DEPTH];
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [AW:0]            count_r, count_nxt_s;
    logic                   empty_r, full_r, ovf_r;
    logic                   wr_req_s, push_s, pop_s, ovf_set_s;

    // Next-state decode; counting happens only on edges that stay in RUN or enter DONE.
    always_comb begin
        state_nxt_s = state_r;
        count_en_s  = 1'b0;
        if (clear_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) state_nxt_s = RUN;
                    else         state_nxt_s = IDLE;
                end
                RUN: begin
                    if (!start_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        count_en_s = 1'b1;
                        if ((limit_i != CNT_ZERO) && (cycle_cnt_r == limit_i - CNT_W'(1)))
                            state_nxt_s = DONE;
                        else
                            state_nxt_s = RUN;
                    end
                end
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register and done flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Saturating cycle and per-channel event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_r <= CNT_ZERO;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt_r[k] <= CNT_ZERO;
        end else if (clear_i) begin
            cycle_cnt_r <= CNT_ZERO;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt_r[k] <= CNT_ZERO;
        end else if (count_en_s) begin
            cycle_cnt_r <= sat_inc(cycle_cnt_r);
            for (int k = 0; k < NUM_EVT; k++)
                if (evt_i[k]) evt_cnt_r[k] <= sat_inc(evt_cnt_r[k]);
        end
    end

    // FIFO handshake: a full FIFO still accepts a write when the head is popped that cycle.
    always_comb begin
        pop_s     = 1'b0;
        wr_req_s  = 1'b0;
        push_s    = 1'b0;
        ovf_set_s = 1'b0;
        if (!clear_i) begin
            pop_s     = trace_rd_i && !empty_r;
            wr_req_s  = (state_r == RUN) && pc_valid_i;
            push_s    = wr_req_s && (!full_r || pop_s);
            ovf_set_s = wr_req_s && full_r && !pop_s;
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {(AW+1){1'b0}});
            full_r  <= (count_nxt_s == DEPTH_C);
            ovf_r   <= ovf_r | ovf_set_s;
        end
    end

    // Trace storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_s) mem_r[wr_ptr_r] <= pc_i;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_EVT; g++) begin : g_evt_out
            assign evt_cnt_o[g*CNT_W +: CNT_W] = evt_cnt_r[g];
        end
    endgenerate

    assign cycle_cnt_o   = cycle_cnt_r;
    assign trace_data_o  = mem_r[rd_ptr_r];
    assign trace_count_o = count_r;
    assign trace_empty_o = empty_r;
    assign trace_full_o  = full_r;
    assign trace_ovf_o   = ovf_r;
    assign done_o        = done_r;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Directed bench for pipe_event_monitor: a vector table for limit/event counting plus
// hand-written sequences for the FIFO, pause/resume, saturation and reset corners.
module tb_pipe_event_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, pc_valid, trace_rd;
    logic [31:0] limit, pc;
    logic [1:0]  evt;

    logic [31:0] cycle_cnt, trace_data;
    logic [63:0] evt_cnt;
    logic [4:0]  trace_count;
    logic        empty, full, ovf, done;

    logic        s_start, s_clear;
    logic [3:0]  s_limit;
    logic [3:0]  s_cycle;
    logic [7:0]  s_evt;
    logic [31:0] s_data;
    logic [4:0]  s_count;
    logic        s_empty, s_full, s_ovf, s_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_event_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
        .evt_i(evt), .pc_i(pc), .pc_valid_i(pc_valid), .trace_rd_i(trace_rd),
        .cycle_cnt_o(cycle_cnt), .evt_cnt_o(evt_cnt), .trace_data_o(trace_data),
        .trace_count_o(trace_count), .trace_empty_o(empty), .trace_full_o(full),
        .trace_ovf_o(ovf), .done_o(done)
    );

    pipe_event_monitor #(.CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear), .limit_i(s_limit),
        .evt_i(evt), .pc_i(pc), .pc_valid_i(1'b0), .trace_rd_i(1'b0),
        .cycle_cnt_o(s_cycle), .evt_cnt_o(s_evt), .trace_data_o(s_data),
        .trace_count_o(s_count), .trace_empty_o(s_empty), .trace_full_o(s_full),
        .trace_ovf_o(s_ovf), .done_o(s_done)
    );

    typedef struct {
        logic        start;
        logic [1:0]  evt;
        logic [31:0] cyc;
        logic [31:0] stall;
        logic [31:0] flush;
        logic        done;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // limit 10, events 01 x3, 11 x2, 10 x1; entry 0 is the uncounted IDLE->RUN edge
        tbl[0]  = '{1'b1, 2'b00, 32'd0,  32'd0, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 32'd1,  32'd1, 32'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'b01, 32'd2,  32'd2, 32'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 32'd3,  32'd3, 32'd0, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 32'd4,  32'd4, 32'd1, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 32'd5,  32'd5, 32'd2, 1'b0};
        tbl[6]  = '{1'b1, 2'b10, 32'd6,  32'd5, 32'd3, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 32'd7,  32'd5, 32'd3, 1'b0};
        tbl[8]  = '{1'b1, 2'b00, 32'd8,  32'd5, 32'd3, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 32'd9,  32'd5, 32'd3, 1'b0};
        tbl[10] = '{1'b1, 2'b00, 32'd10, 32'd5, 32'd3, 1'b1};
        for (int i = 11; i < 16; i++) tbl[i] = '{1'b1, 2'b11, 32'd10, 32'd5, 32'd3, 1'b1};

        rst = 1'b1; start = 1'b0; clear = 1'b0; pc_valid = 1'b0; trace_rd = 1'b0;
        limit = 32'd0; pc = 32'd0; evt = 2'b00;
        s_start = 1'b0; s_clear = 1'b0; s_limit = 4'd0;
        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
        chk("rst_evt",   evt_cnt, 64'd0);
        chk("rst_count", {59'd0, trace_count}, 64'd0);
        chk("rst_flags", {60'd0, empty, full, ovf, done}, 64'h8);
        rst = 1'b1;

        limit = 32'd10;
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            evt   = tbl[i].evt;
            tick();
            chk($sformatf("vec%0d_cycle", i), {32'd0, cycle_cnt}, {32'd0, tbl[i].cyc});
            chk($sformatf("vec%0d_stall", i), {32'd0, evt_cnt[31:0]}, {32'd0, tbl[i].stall});
            chk($sformatf("vec%0d_flush", i), {32'd0, evt_cnt[63:32]}, {32'd0, tbl[i].flush});
            chk($sformatf("vec%0d_done", i), {63'd0, done}, {63'd0, tbl[i].done});
        end

        // clear from DONE
        evt = 2'b00; start = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_cycle", {32'd0, cycle_cnt}, 64'd0);
        chk("clr_evt", evt_cnt, 64'd0);
        chk("clr_done", {63'd0, done}, 64'd0);

        // fill FIFO with 0,4,...,60
        limit = 32'd0; start = 1'b1;
        tick();
        pc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pc = 32'(i * 4);
            tick();
            if (i == 0) begin
                chk("fwft_data", {32'd0, trace_data}, 64'd0);
                chk("fwft_empty", {63'd0, empty}, 64'd0);
            end
        end
        chk("fill_count", {59'd0, trace_count}, 64'd16);
        chk("fill_full_ovf", {62'd0, full, ovf}, 64'h2);
        pc = 32'd64;
        tick();
        pc_valid = 1'b0;
        chk("ovf_set", {63'd0, ovf}, 64'd1);
        chk("ovf_count", {59'd0, trace_count}, 64'd16);
        chk("ovf_head", {32'd0, trace_data}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pop%0d_data", i), {32'd0, trace_data}, 64'(i * 4));
            trace_rd = 1'b1;
            tick();
            trace_rd = 1'b0;
        end
        chk("drain_empty", {63'd0, empty}, 64'd1);
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
        chk("pop_empty_count", {59'd0, trace_count}, 64'd0);

        // full FIFO with simultaneous write and pop
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", {63'd0, ovf}, 64'd0);
        tick();
        pc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pc = 32'(i * 4);
            tick();
        end
        pc = 32'd64; trace_rd = 1'b1;
        tick();
        pc_valid = 1'b0; trace_rd = 1'b0;
        chk("rw_full_count", {59'd0, trace_count}, 64'd16);
        chk("rw_full_ovf", {63'd0, ovf}, 64'd0);
        chk("rw_full_head", {32'd0, trace_data}, 64'd4);
        trace_rd = 1'b1;
        repeat (15) tick();
        trace_rd = 1'b0;
        chk("rw_tail", {32'd0, trace_data}, 64'd64);
        chk("rw_tail_count", {59'd0, trace_count}, 64'd1);

        // pause at 4, resume with limit 8
        clear = 1'b1;
        tick();
        clear = 1'b0;
        limit = 32'd0;
        tick();
        repeat (4) tick();
        chk("pause_pre", {32'd0, cycle_cnt}, 64'd4);
        start = 1'b0;
        repeat (3) tick();
        chk("pause_hold", {32'd0, cycle_cnt}, 64'd4);
        start = 1'b1; limit = 32'd8;
        tick();
        chk("resume_edge", {32'd0, cycle_cnt}, 64'd4);
        repeat (3) tick();
        chk("resume_3", {31'd0, cycle_cnt, done}, {31'd0, 32'd7, 1'b0});
        tick();
        chk("resume_4", {31'd0, cycle_cnt, done}, {31'd0, 32'd8, 1'b1});
        start = 1'b0;
        tick();
        chk("done_ignores_start", {63'd0, done}, 64'd1);

        // limit lowered below the count: no DONE
        clear = 1'b1;
        tick();
        clear = 1'b0; limit = 32'd0; start = 1'b1;
        tick();
        repeat (5) tick();
        limit = 32'd3;
        repeat (3) tick();
        chk("late_limit", {31'd0, cycle_cnt, done}, {31'd0, 32'd8, 1'b0});

        // 4-bit counters saturate
        evt = 2'b01; s_start = 1'b1;
        tick();
        repeat (15) tick();
        chk("sat_15", {60'd0, s_cycle}, 64'd15);
        repeat (5) tick();
        chk("sat_hold", {60'd0, s_cycle}, 64'd15);
        chk("sat_evt", {60'd0, s_evt[3:0]}, 64'd15);
        chk("sat_done", {63'd0, s_done}, 64'd0);
        s_start = 1'b0; s_clear = 1'b1; evt = 2'b00;
        tick();
        s_clear = 1'b0;
        chk("sat_clr", {52'd0, s_cycle, s_evt}, 64'd0);

        // asynchronous reset mid-cycle
        clear = 1'b1;
        tick();
        clear = 1'b0; start = 1'b1; limit = 32'd0; pc = 32'h1234; pc_valid = 1'b1; evt = 2'b11;
        tick();
        repeat (3) tick();
        pc_valid = 1'b0;
        chk("pre_rst_cycle", {32'd0, cycle_cnt}, 64'd3);
        chk("pre_rst_count", {59'd0, trace_count}, 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_cycle", {32'd0, cycle_cnt}, 64'd0);
        chk("async_evt", evt_cnt, 64'd0);
        chk("async_count", {59'd0, trace_count}, 64'd0);
        chk("async_flags", {60'd0, empty, full, ovf, done}, 64'h8);
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
